gsim_accum: RTL and testbench

GSIM_ACCUM -- requirements
Module: gsim_accum

---
 rtl/gsim_pkg.sv | 19 +
 rtl/gsim_sat37.sv | 22 ++
 rtl/gsim_accum.sv | 88 ++++++++
 tb/tb_gsim_accum.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared widths, clamp limits and row-FSM states for the Gauss-Seidel row accumulator.
package gsim_pkg;
  localparam int B_W   = 16;
  localparam int A_W   = 16;
  localparam int X_W   = 32;
  localparam int XR_W  = 37;
  localparam int P_W   = 48;
  localparam int ACC_W = 53;

  localparam logic [XR_W-1:0] X_SAT_MAX = 37'h0F_FFFF_FFFF;
  localparam logic [XR_W-1:0] X_SAT_MIN = 37'h10_0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/gsim_sat37.sv
// Combinational clamp of the 53-bit Q37.16 row sum into signed Q21.16.
module gsim_sat37
  import gsim_pkg::*;
(
  input  logic signed [ACC_W-1:0] sum,
  output logic        [XR_W-1:0]  x_sat,
  output logic                    sat
);
  // The value fits iff every bit from the Q21.16 sign bit upward agrees.
  logic [ACC_W-XR_W:0] hi;

  always_comb begin
    hi  = sum[ACC_W-1:XR_W-1];
    sat = !((&hi) || !(|hi));
    if (!sat)
      x_sat = sum[XR_W-1:0];
    else if (sum[ACC_W-1])
      x_sat = X_SAT_MIN;
    else
      x_sat = X_SAT_MAX;
  end
endmodule

// File: rtl/gsim_accum.sv
// Row accumulator: X_r = b_i - sum(a_ij * x_j), one registered product per term, clamped to Q21.16.
module gsim_accum
  import gsim_pkg::*;
#(
  parameter int MAX_TERMS = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [B_W-1:0]  b_in,
  input  logic                   term_valid,
  output logic                   term_ready,
  input  logic                   term_last,
  input  logic signed [A_W-1:0]  a_in,
  input  logic signed [X_W-1:0]  x_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic        [XR_W-1:0] X_r,
  output logic                   sat_flag
);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [P_W-1:0]   p;
  logic                    p_v;
  logic [CNT_W-1:0]        cnt;

  logic                    term_acc;
  logic                    term_end;
  logic signed [ACC_W-1:0] acc_sub;
  logic        [XR_W-1:0]  x_sat;
  logic                    sat;

  assign in_ready   = (state == IDLE);
  assign term_ready = (state == ACC);
  assign out_valid  = (state == OUT);

  assign term_acc = term_ready && term_valid;
  assign term_end = term_last || (cnt == CNT_W'(MAX_TERMS - 1));
  assign acc_sub  = acc - {{(ACC_W-P_W){p[P_W-1]}}, p};

  gsim_sat37 u_sat (
    .sum   (acc_sub),
    .x_sat (x_sat),
    .sat   (sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      p        <= '0;
      p_v      <= 1'b0;
      cnt      <= '0;
      X_r      <= '0;
      sat_flag <= 1'b0;
    end else begin
      p_v <= term_acc;
      if (term_acc) p <= a_in * x_in;

      // p_v is never set in IDLE, so the row load and the subtract never collide.
      if (state == IDLE && in_valid)
        acc <= {{(ACC_W-B_W-16){b_in[B_W-1]}}, b_in, 16'd0};
      else if (p_v)
        acc <= acc_sub;

      case (state)
        IDLE: if (in_valid) begin
          cnt   <= '0;
          state <= ACC;
        end
        ACC: if (term_valid) begin
          cnt <= cnt + CNT_W'(1);
          if (term_end) state <= DRAIN;
        end
        DRAIN: begin
          X_r      <= x_sat;
          sat_flag <= sat;
          state    <= OUT;
        end
        OUT: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gsim_accum.sv
// Directed bench for gsim_accum with hand-computed Q21.16 results.
module tb_gsim_accum;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] b_in = '0;
  logic               term_valid = 1'b0;
  logic               term_ready;
  logic               term_last = 1'b0;
  logic signed [15:0] a_in = '0;
  logic signed [31:0] x_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [36:0]        X_r;
  logic               sat_flag;

  int total = 0;
  int bad   = 0;

  gsim_accum #(.MAX_TERMS(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .b_in(b_in),
    .term_valid(term_valid), .term_ready(term_ready), .term_last(term_last),
    .a_in(a_in), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .X_r(X_r), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_row(input logic signed [15:0] b);
    @(negedge clk);
    chk("row_in_ready", in_ready, 1);
    in_valid = 1'b1;
    b_in     = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk("row_term_ready", term_ready, 1);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("out_timeout", out_valid, 1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle", in_ready, 1);
    chk("out_drop", out_valid, 0);
  endtask

  task automatic capped_row(input string tag, input logic signed [15:0] b,
                            input logic signed [15:0] a, input logic [36:0] exp);
    start_row(b);
    term_valid = 1'b1; term_last = 1'b0; a_in = a; x_in = 32'h7FFF_FFFF;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 14) chk({tag, "_tready_14"}, term_ready, 1);
      if (i == 15) chk({tag, "_tready_cap"}, term_ready, 0);
    end
    term_valid = 1'b0;
    wait_out();
    chk({tag, "_xr"}, X_r, exp);
    chk({tag, "_sat"}, sat_flag, 1);
    release_out();
  endtask

  // b=100; terms 3*1.5, -2*-1, 5*0.25, 1*16 -> 100-23.75 = 76.25
  logic signed [15:0] ta [4] = '{16'sd3, -16'sd2, 16'sd5, 16'sd1};
  logic signed [31:0] tx [4] = '{32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000, 32'h0010_0000};

  task automatic four_row(input string tag, input bit bubbles);
    start_row(16'sd100);
    for (int i = 0; i < 4; i++) begin
      term_valid = 1'b1; a_in = ta[i]; x_in = tx[i]; term_last = (i == 3);
      @(negedge clk);
      if (bubbles) begin
        term_valid = 1'b0;
        @(negedge clk);
      end
    end
    term_valid = 1'b0; term_last = 1'b0;
    wait_out();
    chk({tag, "_xr"}, X_r, 37'h00_004C_4000);
    chk({tag, "_sat"}, sat_flag, 0);
    release_out();
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_term_ready", term_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xr", X_r, 0);
    chk("rst_sat", sat_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single term: 16 - 2*2.0 = 12.0
    start_row(16'sd16);
    term_valid = 1'b1; a_in = 16'sd2; x_in = 32'h0002_0000; term_last = 1'b1;
    @(negedge clk);
    term_valid = 1'b0; term_last = 1'b0;
    chk("t1_drain_ov", out_valid, 0);
    chk("t1_drain_tr", term_ready, 0);
    @(negedge clk);
    chk("t1_ov", out_valid, 1);
    chk("t1_xr", X_r, 37'h00_000C_0000);
    chk("t1_sat", sat_flag, 0);
    release_out();

    capped_row("t2", 16'sd32767, -16'sd32768, 37'h0F_FFFF_FFFF);
    capped_row("t3", -16'sd32768, 16'sd32767, 37'h10_0000_0000);

    four_row("t4_b2b", 1'b0);
    four_row("t4_bub", 1'b1);

    // hold in OUT: -5 - 1*0.5 = -5.5; in_valid and term_valid must be ignored
    start_row(-16'sd5);
    term_valid = 1'b1; a_in = 16'sd1; x_in = 32'h0000_8000; term_last = 1'b1;
    @(negedge clk);
    term_valid = 1'b0; term_last = 1'b0;
    wait_out();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; term_valid = 1'b1; b_in = 16'sd77;
      @(negedge clk);
      chk("t5_hold_ov", out_valid, 1);
      chk("t5_hold_xr", X_r, 37'h1F_FFFA_8000);
      chk("t5_hold_ir", in_ready, 0);
    end
    in_valid = 1'b0; term_valid = 1'b0;
    chk("t5_sat", sat_flag, 0);
    release_out();
    @(negedge clk);
    chk("t5_stay_idle", in_ready, 1);

    // async reset mid-ACC
    start_row(16'sd1000);
    term_valid = 1'b1; a_in = 16'sd7; x_in = 32'h0003_0000; term_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ir", in_ready, 1);
    chk("t6_rst_tr", term_ready, 0);
    chk("t6_rst_ov", out_valid, 0);
    chk("t6_rst_xr", X_r, 0);
    chk("t6_rst_sat", sat_flag, 0);
    term_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_row(16'sd16);
    term_valid = 1'b1; a_in = 16'sd2; x_in = 32'h0002_0000; term_last = 1'b1;
    @(negedge clk);
    term_valid = 1'b0; term_last = 1'b0;
    wait_out();
    chk("t6_xr", X_r, 37'h00_000C_0000);
    chk("t6_sat", sat_flag, 0);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
